// File: rtl/tree_walker.sv
// tree_walker: walks the message-hierarchy tree one OPEN/CLOSE command
// at a time, scanning the tree table and node ROM to resolve each child.
module tree_walker #(
    parameter int NUM_MSG_HIERARCHY   = 4,
    parameter int MAX_NODES_PER_LEVEL = 8,
    parameter int ADDR_W              = 8,
    parameter int ID_W                = 16,
    localparam int LVL_W  = (NUM_MSG_HIERARCHY > 1) ?
                            $clog2(NUM_MSG_HIERARCHY) : 1,
    localparam int SLOT_W = (MAX_NODES_PER_LEVEL > 1) ?
                            $clog2(MAX_NODES_PER_LEVEL) : 1,
    localparam int CL_W   = $clog2(NUM_MSG_HIERARCHY + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_close,
    input  logic [ID_W-1:0]   in_id,
    output logic              tbl_rd_en,
    output logic [LVL_W-1:0]  tbl_rd_level,
    output logic [SLOT_W-1:0] tbl_rd_slot,
    input  logic [ADDR_W-1:0] tbl_node_addr,
    input  logic [ADDR_W-1:0] tbl_parent_addr,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_rd_addr,
    input  logic [ID_W-1:0]   rom_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_node_addr,
    output logic [CL_W-1:0]   out_level,
    output logic [1:0]        out_err,
    output logic [CL_W-1:0]   cur_level,
    output logic [ADDR_W-1:0] cur_node
);

    localparam logic [1:0] E_OK   = 2'd0;
    localparam logic [1:0] E_MISS = 2'd1;
    localparam logic [1:0] E_OVF  = 2'd2;
    localparam logic [1:0] E_UDF  = 2'd3;

    localparam logic [CL_W-1:0]   LVL_MAX   = CL_W'(NUM_MSG_HIERARCHY);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MAX_NODES_PER_LEVEL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_TCHK,
        S_RCHK,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CL_W-1:0]     r_lvl;
    logic [ADDR_W-1:0]   r_path [NUM_MSG_HIERARCHY];
    logic [SLOT_W-1:0]   r_k;
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [LVL_W-1:0]    r_tbl_lvl;
    logic [SLOT_W-1:0]   r_tbl_slot;
    logic [ADDR_W-1:0]   r_out_node;
    logic [CL_W-1:0]     r_out_lvl;
    logic [1:0]          r_out_err;

    logic [LVL_W-1:0]    w_lvl_idx;
    logic [LVL_W-1:0]    w_lvl_m1;
    logic [LVL_W-1:0]    w_lvl_m2;
    logic [ADDR_W-1:0]   w_cur_node;
    logic                w_pm;
    logic                w_hit;
    logic                w_last;
    logic                w_start;
    logic                w_adv;
    logic                w_rom_go;
    logic                w_desc;
    logic                w_rewind;
    logic                w_fail;
    logic [1:0]          w_err;

    assign w_lvl_idx  = LVL_W'(r_lvl);
    assign w_lvl_m1   = LVL_W'(r_lvl - 1'b1);
    assign w_lvl_m2   = LVL_W'(r_lvl - 2'd2);
    assign w_cur_node = (r_lvl == '0) ? '0 : r_path[w_lvl_m1];

    // A slot is a candidate only if it is occupied and hangs off the current node
    assign w_pm   = (tbl_node_addr != '0) && (tbl_parent_addr == w_cur_node);
    assign w_hit  = (rom_id == r_id);
    assign w_last = (r_k == SLOT_LAST);

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_adv    = 1'b0;
        w_rom_go = 1'b0;
        w_desc   = 1'b0;
        w_rewind = 1'b0;
        w_fail   = 1'b0;
        w_err    = E_OK;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (!in_close && (r_lvl < LVL_MAX)) begin
                        w_start = 1'b1;
                        w_next  = S_SCAN;
                    end else begin
                        w_next = S_RESP;
                        if (!in_close) begin
                            w_fail = 1'b1;
                            w_err  = E_OVF;
                        end else if (r_lvl == '0) begin
                            w_fail = 1'b1;
                            w_err  = E_UDF;
                        end else begin
                            w_rewind = 1'b1;
                        end
                    end
                end
            end
            S_SCAN: begin
                w_next = S_TCHK;
            end
            S_TCHK: begin
                if (w_pm) begin
                    w_rom_go = 1'b1;
                    w_next   = S_RCHK;
                end else if (w_last) begin
                    w_fail = 1'b1;
                    w_err  = E_MISS;
                    w_next = S_RESP;
                end else begin
                    w_adv  = 1'b1;
                    w_next = S_SCAN;
                end
            end
            S_RCHK: begin
                if (w_hit) begin
                    w_desc = 1'b1;
                    w_next = S_RESP;
                end else if (w_last) begin
                    w_fail = 1'b1;
                    w_err  = E_MISS;
                    w_next = S_RESP;
                end else begin
                    w_adv  = 1'b1;
                    w_next = S_SCAN;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_lvl      <= '0;
            r_k        <= '0;
            r_id       <= '0;
            r_addr     <= '0;
            r_tbl_lvl  <= '0;
            r_tbl_slot <= '0;
            r_out_node <= '0;
            r_out_lvl  <= '0;
            r_out_err  <= E_OK;
            for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
                r_path[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_id       <= in_id;
                r_k        <= '0;
                r_tbl_lvl  <= w_lvl_idx;
                r_tbl_slot <= '0;
            end
            if (w_adv) begin
                r_k        <= r_k + 1'b1;
                r_tbl_slot <= r_k + 1'b1;
            end
            if (w_rom_go) begin
                r_addr <= tbl_node_addr;
            end
            if (w_desc) begin
                r_path[w_lvl_idx] <= r_addr;
                r_lvl      <= r_lvl + 1'b1;
                r_out_node <= r_addr;
                r_out_lvl  <= r_lvl + 1'b1;
                r_out_err  <= E_OK;
            end
            if (w_rewind) begin
                r_lvl      <= r_lvl - 1'b1;
                r_out_node <= (r_lvl == CL_W'(1)) ? '0 : r_path[w_lvl_m2];
                r_out_lvl  <= r_lvl - 1'b1;
                r_out_err  <= E_OK;
            end
            if (w_fail) begin
                r_out_node <= '0;
                r_out_lvl  <= r_lvl;
                r_out_err  <= w_err;
            end
        end
    end

    // ROM address is forwarded straight from the table data in the check cycle
    assign in_ready      = rst_n && (r_state == S_IDLE);
    assign tbl_rd_en     = (r_state == S_SCAN);
    assign tbl_rd_level  = r_tbl_lvl;
    assign tbl_rd_slot   = r_tbl_slot;
    assign rom_rd_en     = w_rom_go;
    assign rom_rd_addr   = w_rom_go ? tbl_node_addr : r_addr;
    assign out_valid     = (r_state == S_RESP);
    assign out_node_addr = r_out_node;
    assign out_level     = r_out_lvl;
    assign out_err       = r_out_err;
    assign cur_level     = r_lvl;
    assign cur_node      = w_cur_node;

endmodule
